// File: rtl/mc_sim_pkg.sv
// mc_sim_pkg: opcodes, functs, FSM states and error codes for mc_simulator.
// Shared by the core and its ALU.
package mc_sim_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_DADDR   = 2'd2,
        ERR_FETCH   = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_sim_alu.sv
// mc_sim_alu: combinational ALU for mc_simulator.
// Signed compare for SLT, shift applies shamt to operand b.
module mc_sim_alu
    import mc_sim_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLL: result = b << shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mc_simulator.sv
// mc_simulator: multi-cycle MIPS-subset core with local instr/data memories.
// Define MC_SIM_JUMP_EN to add J/JAL.
module mc_simulator
    import mc_sim_pkg::*;
#(
    parameter int          INSTR_NUM = 256,
    parameter int          DATA_NUM  = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    output logic [2:0]  state_o,
    output logic        retire_o,
    output logic [31:0] retired_cnt_o,
    output logic        halt_o,
    output logic [1:0]  err_o
);

    localparam int IW = $clog2(INSTR_NUM);
    localparam int DW = $clog2(DATA_NUM);

    logic        [31:0] Instr_Mem [0:INSTR_NUM-1];
    logic        [31:0] Data_Mem  [0:DATA_NUM-1];
    logic signed [31:0] Reg_File  [0:31];

    state_t      state, state_nx;
    err_t        err, err_nx;
    logic [31:0] pc, pc_nx, ir, op_a, op_b, imm, alu_q, mdr, cnt;
    logic        retire_q, retire_nx;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_res;
    logic        alu_zero;

    logic        is_r, is_imm, is_lw, is_sw, is_br, is_j, is_jal, legal;
    logic        fetch_bad, data_bad, taken;
    logic [31:0] pc_plus4, br_target;
    logic        rf_we, dm_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];

    always_comb begin
        is_r   = 1'b0;
        is_imm = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_br  = 1'b0;
        is_j   = 1'b0;
        is_jal = 1'b0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                is_r = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    default: is_r = 1'b0;
                endcase
            end
            OP_ADDI: is_imm = 1'b1;
            OP_SLTI: begin
                is_imm = 1'b1;
                alu_op = ALU_SLT;
            end
            OP_LW: is_lw = 1'b1;
            OP_SW: is_sw = 1'b1;
            OP_BEQ, OP_BNE: begin
                is_br  = 1'b1;
                alu_op = ALU_SUB;
            end
`ifdef MC_SIM_JUMP_EN
            OP_J:   is_j   = 1'b1;
            OP_JAL: is_jal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign legal = is_r | is_imm | is_lw | is_sw | is_br | is_j | is_jal;
    assign alu_b = (is_r || is_br) ? op_b : imm;

    mc_sim_alu u_alu (
        .op     (alu_op),
        .a      (op_a),
        .b      (alu_b),
        .shamt  (shamt),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign fetch_bad = (pc[1:0] != 2'b00) || (|pc[31:IW+2]);
    assign data_bad  = (alu_q[1:0] != 2'b00) || (|alu_q[31:DW+2]);
    assign taken     = alu_zero ^ (opcode == OP_BNE);
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm[29:0], 2'b00};

    always_comb begin
        state_nx  = state;
        err_nx    = err;
        pc_nx     = pc;
        retire_nx = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = rt;
        rf_wd     = alu_q;
        dm_we     = 1'b0;
        unique case (state)
            S_IF: begin
                if (fetch_bad) begin
                    state_nx = S_HALT;
                    err_nx   = ERR_FETCH;
                end else begin
                    state_nx = S_ID;
                end
            end
            S_ID: begin
                if (ir == HALT_WORD) begin
                    state_nx = S_HALT;
                end else if (!legal) begin
                    state_nx = S_HALT;
                    err_nx   = ERR_ILLEGAL;
                end else begin
                    state_nx = S_EX;
                end
            end
            S_EX: begin
                unique case (1'b1)
                    is_br: begin
                        retire_nx = 1'b1;
                        pc_nx     = taken ? br_target : pc_plus4;
                        state_nx  = S_IF;
                    end
                    is_lw, is_sw: state_nx = S_MEM;
`ifdef MC_SIM_JUMP_EN
                    is_j, is_jal: begin
                        retire_nx = 1'b1;
                        pc_nx     = {pc_plus4[31:28], ir[25:0], 2'b00};
                        rf_we     = is_jal;
                        rf_wa     = 5'd31;
                        rf_wd     = pc_plus4;
                        state_nx  = S_IF;
                    end
`endif
                    default: state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (data_bad) begin
                    state_nx = S_HALT;
                    err_nx   = ERR_DADDR;
                end else if (is_sw) begin
                    dm_we     = 1'b1;
                    retire_nx = 1'b1;
                    pc_nx     = pc_plus4;
                    state_nx  = S_IF;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_wa     = is_r ? rd : rt;
                rf_wd     = is_lw ? mdr : alu_q;
                retire_nx = 1'b1;
                pc_nx     = pc_plus4;
                state_nx  = S_IF;
            end
            S_HALT: ;
            default: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IF;
        else       state <= state_nx;
    end

    // Reset wins over every write issued by the state being left.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc       <= RESET_PC;
            err      <= ERR_NONE;
            retire_q <= 1'b0;
            cnt      <= '0;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            imm      <= '0;
            alu_q    <= '0;
            mdr      <= '0;
            Reg_File <= '{default: '0};
            Data_Mem <= '{default: '0};
        end else begin
            pc       <= pc_nx;
            err      <= err_nx;
            retire_q <= retire_nx;
            if (retire_nx) cnt <= cnt + 32'd1;
            if (state == S_IF && !fetch_bad) ir <= Instr_Mem[pc[IW+1:2]];
            if (state == S_ID) begin
                op_a <= (rs == 5'd0) ? 32'd0 : Reg_File[rs];
                op_b <= (rt == 5'd0) ? 32'd0 : Reg_File[rt];
                imm  <= sext16(ir[15:0]);
            end
            if (state == S_EX) alu_q <= alu_res;
            if (state == S_MEM && !data_bad) mdr <= Data_Mem[alu_q[DW+1:2]];
            if (dm_we) Data_Mem[alu_q[DW+1:2]] <= op_b;
            if (rf_we && rf_wa != 5'd0) Reg_File[rf_wa] <= rf_wd;
        end
    end

    assign pc_o          = pc;
    assign state_o       = state;
    assign retire_o      = retire_q;
    assign retired_cnt_o = cnt;
    assign halt_o        = (state == S_HALT);
    assign err_o         = err;

endmodule

// File: tb/tb_mc_simulator.sv
// tb_mc_simulator: table-driven program vectors plus reset corner sequences.
// Runs the default build (jump opcodes illegal).
module tb_mc_simulator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_o;
    logic [2:0]  state_o;
    logic        retire_o;
    logic [31:0] retired_cnt_o;
    logic        halt_o;
    logic [1:0]  err_o;

    mc_simulator dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_o          (pc_o),
        .state_o       (state_o),
        .retire_o      (retire_o),
        .retired_cnt_o (retired_cnt_o),
        .halt_o        (halt_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    localparam logic [31:0] H = 32'hFFFF_FFFF;

    typedef struct {
        logic [95:0]      name;
        logic [7:0][31:0] prog;
        int               rn;
        logic [31:0]      rv;
        int               rn2;
        logic [31:0]      rv2;
        int               cnt;
        logic [1:0]       err;
        logic [31:0]      pce;
        int               li;
        int               lat;
        int               gap;
        int               dmi;
        logic [31:0]      dmv;
        int               pci;
        logic [31:0]      pcv;
    } vec_t;

    vec_t vecs [11];
    int   n_chk = 0;
    int   n_fail = 0;
    int   if_t[$];
    int   ret_t[$];
    logic [31:0] if_pc[$];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [7:0][31:0] p8(input logic [31:0] w0, w1, w2, w3,
                                            input logic [31:0] w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0][31:0] prog);
        for (int i = 0; i < 256; i++) dut.Instr_Mem[i] = H;
        for (int i = 0; i < 8; i++) dut.Instr_Mem[i] = prog[i];
    endtask

    task automatic do_reset(input logic [7:0][31:0] prog);
        @(negedge clk_i);
        rst_i = 1'b1;
        load(prog);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst state", {29'd0, state_o}, 32'd0);
        chk("rst pc", pc_o, 32'h0);
        chk("rst cnt", retired_cnt_o, 32'd0);
        chk("rst flags", {28'd0, retire_o, halt_o, err_o}, 32'd0);
    endtask

    task automatic run_prog(input int budget);
        logic [2:0] prev;
        prev = 3'd7;
        if_t.delete();
        ret_t.delete();
        if_pc.delete();
        for (int c = 0; c < budget; c++) begin
            if (state_o == 3'd0 && prev != 3'd0) begin
                if_t.push_back(cyc);
                if_pc.push_back(pc_o);
            end
            if (retire_o) ret_t.push_back(cyc);
            prev = state_o;
            if (halt_o) break;
            @(negedge clk_i);
        end
    endtask

    initial begin
        vecs[0] = '{"add_chain", p8(enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 0, 2, 16'hFFFD),
                    enc_r(6'h20, 3, 1, 2, 0), H, H, H, H, H),
                    3, 32'd2, 0, 32'd0, 3, 2'd0, 32'hC, 2, 4, 4, -1, 0, -1, 0};
        vecs[1] = '{"sw_lw", p8(enc_i(6'h08, 0, 1, 16'd8), enc_i(6'h2b, 0, 1, 16'd4),
                    enc_i(6'h23, 0, 4, 16'd4), H, H, H, H, H),
                    4, 32'd8, 1, 32'd8, 3, 2'd0, 32'hC, 2, 5, 4, 1, 32'd8, -1, 0};
        vecs[2] = '{"beq_taken", p8(enc_i(6'h08, 0, 1, 16'd7), enc_i(6'h08, 0, 2, 16'd7),
                    enc_i(6'h08, 0, 7, 16'd1), enc_i(6'h08, 0, 7, 16'd2),
                    enc_i(6'h04, 1, 2, 16'd2), enc_i(6'h08, 0, 8, 16'd1),
                    enc_i(6'h08, 0, 8, 16'd2), H),
                    8, 32'd0, 7, 32'd2, 5, 2'd0, 32'h1C, 4, 3, 4, -1, 0, 5, 32'h1C};
        vecs[3] = '{"bne_fall", p8(enc_i(6'h08, 0, 1, 16'd7), enc_i(6'h08, 0, 2, 16'd7),
                    enc_i(6'h08, 0, 7, 16'd1), enc_i(6'h08, 0, 7, 16'd2),
                    enc_i(6'h05, 1, 2, 16'd2), enc_i(6'h08, 0, 8, 16'd1),
                    enc_i(6'h08, 0, 8, 16'd2), H),
                    8, 32'd2, 7, 32'd2, 7, 2'd0, 32'h1C, 4, 3, 4, -1, 0, 5, 32'h14};
        vecs[4] = '{"lw_misalign", p8(enc_i(6'h08, 0, 5, 16'd3), enc_i(6'h23, 0, 5, 16'd2),
                    H, H, H, H, H, H),
                    5, 32'd3, 0, 32'd0, 1, 2'd2, 32'h4, 0, 4, -1, -1, 0, 1, 32'h4};
        vecs[5] = '{"r0_wrap", p8(enc_i(6'h08, 0, 0, 16'd9), enc_i(6'h08, 0, 6, 16'h7FFF),
                    enc_r(6'h00, 6, 0, 6, 16), enc_r(6'h20, 6, 6, 6, 0), H, H, H, H),
                    0, 32'd0, 6, 32'hFFFE_0000, 4, 2'd0, 32'h10, 2, 4, 4, -1, 0, -1, 0};
        vecs[6] = '{"jump_illeg", p8(enc_i(6'h08, 0, 1, 16'd1), {6'h02, 26'd0},
                    H, H, H, H, H, H),
                    1, 32'd1, 0, 32'd0, 1, 2'd1, 32'h4, 0, 4, -1, -1, 0, -1, 0};
        vecs[7] = '{"funct_illeg", p8(enc_i(6'h08, 0, 1, 16'd1), enc_r(6'h21, 3, 1, 1, 0),
                    H, H, H, H, H, H),
                    3, 32'd0, 1, 32'd1, 1, 2'd1, 32'h4, -1, 0, -1, -1, 0, -1, 0};
        vecs[8] = '{"fetch_fault", p8(enc_i(6'h04, 0, 0, 16'h00FF), H, H, H, H, H, H, H),
                    0, 32'd0, 0, 32'd0, 1, 2'd3, 32'h400, 0, 3, -1, -1, 0, 1, 32'h400};
        vecs[9] = '{"slt_signed", p8(enc_i(6'h08, 0, 1, 16'hFFFF), enc_i(6'h0a, 1, 2, 16'd1),
                    enc_r(6'h2a, 3, 1, 0, 0), H, H, H, H, H),
                    2, 32'd1, 3, 32'd1, 3, 2'd0, 32'hC, -1, 0, -1, -1, 0, -1, 0};
        vecs[10] = '{"logic_sub", p8(enc_i(6'h08, 0, 1, 16'hC), enc_i(6'h08, 0, 2, 16'hA),
                     enc_r(6'h24, 3, 1, 2, 0), enc_r(6'h25, 4, 3, 2, 0),
                     enc_r(6'h22, 5, 2, 1, 0), H, H, H),
                     4, 32'hA, 5, 32'hFFFF_FFFE, 5, 2'd0, 32'h14, -1, 0, -1, -1, 0, -1, 0};

        for (int v = 0; v < 11; v++) begin
            string nm;
            nm = $sformatf("%0s", vecs[v].name);
            do_reset(vecs[v].prog);
            run_prog(400);
            chk({nm, " halt"}, {31'd0, halt_o}, 32'd1);
            repeat (4) @(negedge clk_i);
            chk({nm, " state"}, {29'd0, state_o}, 32'd5);
            chk({nm, " pc"}, pc_o, vecs[v].pce);
            chk({nm, " cnt"}, retired_cnt_o, vecs[v].cnt);
            chk({nm, " err"}, {30'd0, err_o}, {30'd0, vecs[v].err});
            chk({nm, " retire"}, {31'd0, retire_o}, 32'd0);
            chk({nm, " reg_a"}, dut.Reg_File[vecs[v].rn], vecs[v].rv);
            chk({nm, " reg_b"}, dut.Reg_File[vecs[v].rn2], vecs[v].rv2);
            if (vecs[v].li >= 0) begin
                if (ret_t.size() > vecs[v].li && if_t.size() > vecs[v].li)
                    chk({nm, " lat"}, ret_t[vecs[v].li] - if_t[vecs[v].li], vecs[v].lat);
                else
                    chk({nm, " lat_seen"}, 32'd0, 32'd1);
            end
            if (vecs[v].gap >= 0) begin
                if (ret_t.size() > 1)
                    chk({nm, " gap"}, ret_t[1] - ret_t[0], vecs[v].gap);
                else
                    chk({nm, " gap_seen"}, 32'd0, 32'd1);
            end
            if (vecs[v].dmi >= 0)
                chk({nm, " dmem"}, dut.Data_Mem[vecs[v].dmi], vecs[v].dmv);
            if (vecs[v].pci >= 0) begin
                if (if_pc.size() > vecs[v].pci)
                    chk({nm, " next_pc"}, if_pc[vecs[v].pci], vecs[v].pcv);
                else
                    chk({nm, " next_pc_seen"}, 32'd0, 32'd1);
            end
        end

        // Reset during MEM of a store must cancel the store.
        begin
            logic [7:0][31:0] sp;
            bit hit;
            sp = p8(enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h2b, 0, 1, 16'd0), H, H, H, H, H, H);
            do_reset(sp);
            hit = 1'b0;
            for (int c = 0; c < 50; c++) begin
                if (state_o == 3'd3 && retired_cnt_o == 32'd1) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk_i);
            end
            chk("sw_mem reached", {31'd0, hit}, 32'd1);
            rst_i = 1'b1;
            @(negedge clk_i);
            chk("mid_rst state", {29'd0, state_o}, 32'd0);
            chk("mid_rst pc", pc_o, 32'h0);
            chk("mid_rst dmem0", dut.Data_Mem[0], 32'd0);
            chk("mid_rst reg1", dut.Reg_File[1], 32'd0);
            chk("mid_rst cnt", retired_cnt_o, 32'd0);
            rst_i = 1'b0;
            run_prog(100);
            chk("rerun halt", {31'd0, halt_o}, 32'd1);
            chk("rerun dmem0", dut.Data_Mem[0], 32'd5);
            chk("rerun cnt", retired_cnt_o, 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
